commit_trace_buf: RTL

- Parametrised commit-trace recorder for the single-cycle RISC-V core, beside the core top level.
- Records every retired instruction {pc, inst} into a DEPTH-entry ring buffer.
- Detects a halt trigger (ebreak, ecall, or an external pulse), captures POST_TRIG further commits, then freezes.
- Streams the frozen history oldest-first over a valid/ready port to the sim harness or a debug bridge.

---
 rtl/commit_trace_buf.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/commit_trace_buf.sv
// -----------------------------------------------------------------------------
// commit_trace_buf
//   Commit-trace recorder that sits beside the single-cycle RISC-V core.
//   Every retired instruction {pc, inst} goes into a DEPTH-entry ring. A halt
//   trigger (ebreak, ecall or trig_ext) starts a POST_TRIG-commit tail, and
//   then the ring freezes. The frozen history streams out oldest-first over a
//   valid/ready port. The block only observes the core and never stalls it.
//
//   Optional feature macro: COMMIT_TRACE_CYCLE_STAMP_EN
//     defined   : each entry also stores a free-running cycle stamp, which is
//                 presented on out_cycle
//     undefined : there is no cycle counter or stamp storage; out_cycle = 0
//
// Ports
//   clk, rstn                  clock; asynchronous active-low reset
//   commit_valid/pc/inst       retire stream from the core
//   trig_ext                   external trigger, sampled every cycle
//   arm                        re-arm pulse, acts only in FROZEN
//   dump_req                   start readout, acts only in FROZEN
//   halt, frozen, count        status outputs
//   out_valid/ready/pc/inst/cycle/last   readout stream
//
// state    | meaning
// ---------+----------------------------------------------------------
// CAPTURE  | recording every commit and watching for a trigger
// POST     | trigger seen; recording the remaining post-trigger commits
// FROZEN   | ring is held; waiting for dump_req or arm
// DUMP     | streaming the held entries oldest-first
// -----------------------------------------------------------------------------
module commit_trace_buf #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int CYC_W     = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [31:0]              commit_inst,
    input  logic                     trig_ext,
    input  logic                     arm,
    input  logic                     dump_req,
    output logic                     halt,
    output logic                     frozen,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_inst,
    output logic [CYC_W-1:0]         out_cycle,
    output logic                     out_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;

    typedef enum logic [1:0] {
        ST_CAPTURE,
        ST_POST,
        ST_FROZEN,
        ST_DUMP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_post_cnt;
    logic [CW-1:0]     r_remaining;
    logic              r_halt;

    logic [XLEN-1:0]   r_mem_pc   [DEPTH];
    logic [31:0]       r_mem_inst [DEPTH];

    logic              w_is_sys;
    logic              w_wr_en;
    logic              w_trig;
    logic              w_post_dec;
    logic              w_arm;
    logic              w_dump_start;
    logic              w_rd_adv;

    assign w_is_sys = (commit_inst == INST_EBREAK) || (commit_inst == INST_ECALL);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_CAPTURE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_trig       = 1'b0;
        w_post_dec   = 1'b0;
        w_arm        = 1'b0;
        w_dump_start = 1'b0;
        w_rd_adv     = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                w_wr_en = commit_valid;
                // trig_ext alone triggers without writing an entry
                w_trig  = (commit_valid && w_is_sys) || trig_ext;
                if (w_trig) begin
                    w_state_nxt = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
                end
            end
            ST_POST: begin
                w_wr_en    = commit_valid;
                w_post_dec = commit_valid;
                if (commit_valid && (r_post_cnt == CW'(1))) begin
                    w_state_nxt = ST_FROZEN;
                end
            end
            ST_FROZEN: begin
                if (arm) begin
                    w_arm       = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end else if (dump_req && (r_count != '0)) begin
                    w_dump_start = 1'b1;
                    w_state_nxt  = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (out_ready) begin
                    w_rd_adv = 1'b1;
                    if (r_remaining == CW'(1)) begin
                        w_state_nxt = ST_FROZEN;
                    end
                end
            end
            default: w_state_nxt = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_remaining <= '0;
            r_halt      <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_count != CW'(DEPTH)) begin
                    r_count <= r_count + CW'(1);
                end
            end
            if (w_trig) begin
                r_post_cnt <= CW'(POST_TRIG);
                r_halt     <= 1'b1;
            end else if (w_post_dec) begin
                r_post_cnt <= r_post_cnt - CW'(1);
            end
            if (w_arm) begin
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_halt   <= 1'b0;
            end
            // with a full ring the low bits of count are zero, so the
            // oldest entry is the one wr_ptr is about to overwrite
            if (w_dump_start) begin
                r_rd_ptr    <= r_wr_ptr - r_count[AW-1:0];
                r_remaining <= r_count;
            end else if (w_rd_adv) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_remaining <= r_remaining - CW'(1);
            end
        end
    end

    // storage carries no reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_pc[r_wr_ptr]   <= commit_pc;
            r_mem_inst[r_wr_ptr] <= commit_inst;
        end
    end

`ifdef COMMIT_TRACE_CYCLE_STAMP_EN
    logic [CYC_W-1:0]  r_cyc;
    logic [CYC_W-1:0]  r_mem_cyc [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cyc <= '0;
        end else begin
            r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_cyc[r_wr_ptr] <= r_cyc;
        end
    end

    assign out_cycle = r_mem_cyc[r_rd_ptr];
`else
    assign out_cycle = '0;
`endif

    assign halt      = r_halt;
    assign frozen    = (r_state == ST_FROZEN);
    assign count     = r_count;
    assign out_valid = (r_state == ST_DUMP);
    assign out_last  = (r_state == ST_DUMP) && (r_remaining == CW'(1));
    assign out_pc    = r_mem_pc[r_rd_ptr];
    assign out_inst  = r_mem_inst[r_rd_ptr];

endmodule
